// File: rtl/data_mem_responder.sv
// Slow data-memory responder: services processor loads/stores from an internal
// word RAM while stalling the core with hold for LATENCY cycles per access.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_address,
    input  logic [31:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             init_we,
    input  logic [31:0]      init_addr,
    input  logic [31:0]      init_data,
    output logic [31:0]      data,
    output logic             hold,
    output logic             err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int WAIT_CYC = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam logic [3:0]       CNT_INIT = 4'(WAIT_CYC);
    localparam logic [3:0]       CNT_DEC  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_isStore;
    logic          r_legal;
    logic [31:0]   r_data;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_idle;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_initIdx;
    logic          w_legal;
    logic          w_initLegal;
    logic          w_enterDone;
    logic [AW-1:0] w_rdIdx;
    logic          w_rdLegal;
    logic          w_rdStore;
    logic          w_commit;
    logic          w_commitStore;
    logic [AW-1:0] w_commitIdx;
    logic [31:0]   w_commitData;
    logic          w_initOk;

    // Legal means word aligned and no address bit above the word-index field set.
    function automatic logic addrLegal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    assign w_req       = mem_read | mem_write;
    assign w_idle      = (r_state == S_IDLE);
    assign w_idx       = data_address[AW+1:2];
    assign w_initIdx   = init_addr[AW+1:2];
    assign w_legal     = addrLegal(data_address);
    assign w_initLegal = addrLegal(init_addr);

    // With LATENCY==1 the DONE read happens straight out of IDLE, before anything is latched.
    always_comb begin
        w_enterDone = 1'b0;
        w_rdIdx     = r_idx;
        w_rdLegal   = r_legal;
        w_rdStore   = r_isStore;
        if (LATENCY == 1) begin
            w_enterDone = w_idle & w_req;
            w_rdIdx     = w_idx;
            w_rdLegal   = w_legal;
            w_rdStore   = mem_write;
        end else if (LATENCY >= 2) begin
            w_enterDone = (r_state == S_WAIT) && (r_cnt == 4'd0);
        end
    end

    always_comb begin
        w_commit      = 1'b0;
        w_commitStore = 1'b0;
        w_commitIdx   = r_idx;
        w_commitData  = r_wdata;
        if (LATENCY == 0) begin
            w_commit      = reset & w_req & w_legal;
            w_commitStore = mem_write;
            w_commitIdx   = w_idx;
            w_commitData  = write_data;
        end else begin
            w_commit      = reset & (r_state == S_DONE) & r_legal;
            w_commitStore = r_isStore;
        end
        w_initOk = reset & init_we & w_initLegal & w_idle & ~w_req;
    end

    // RAM has no reset so its contents survive a processor reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_commitStore) begin
            r_mem[w_commitIdx] <= w_commitData;
        end else if (w_initOk) begin
            r_mem[w_initIdx] <= init_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_isStore <= 1'b0;
            r_legal   <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (w_commit) begin
                if (w_commitStore) begin
                    if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_ONE;
                end else if (rd_count != CNT_MAX) begin
                    rd_count <= rd_count + CNT_ONE;
                end
            end
            r_err <= w_enterDone & ~w_rdLegal;
            if (w_enterDone) begin
                if (!w_rdLegal) begin
                    r_data <= '0;
                end else if (!w_rdStore) begin
                    r_data <= r_mem[w_rdIdx];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req && (LATENCY > 0)) begin
                        r_idx     <= w_idx;
                        r_wdata   <= write_data;
                        r_isStore <= mem_write;
                        r_legal   <= w_legal;
                        r_cnt     <= CNT_INIT;
                        r_state   <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_DEC;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // hold rises combinationally in the request cycle so the core never commits early.
    assign hold = reset & (LATENCY > 0) & ((w_idle & w_req) | (r_state == S_WAIT));
    assign data = (LATENCY == 0) ? (w_legal ? r_mem[w_idx] : '0) : r_data;
    assign err  = (LATENCY == 0) ? (reset & w_req & ~w_legal) : r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a slow (LATENCY=2) instance and a
// zero-latency instance with narrow counters.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataAddress, writeData, initAddr, initData;
    logic        memRead, memWrite, initWe;
    logic [31:0] dataOut;
    logic        holdOut, errOut;
    logic [15:0] rdCount, wrCount;

    logic        fReset;
    logic [31:0] fAddress, fWriteData;
    logic        fRead, fWrite;
    logic [31:0] fData;
    logic        fHold, fErr;
    logic [1:0]  fRdCount, fWrCount;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chkData;
        logic        isStore;
        logic        legal;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] modelMem [256];
    logic [31:0] lastData = '0;
    int          expRd = 0;
    int          expWr = 0;
    int          fastWr = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .data_address(dataAddress), .write_data(writeData),
        .mem_read(memRead), .mem_write(memWrite), .init_we(initWe), .init_addr(initAddr),
        .init_data(initData), .data(dataOut), .hold(holdOut), .err(errOut),
        .rd_count(rdCount), .wr_count(wrCount)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0), .CNT_W(2)) u_fast (
        .clk(clk), .reset(fReset), .data_address(fAddress), .write_data(fWriteData),
        .mem_read(fRead), .mem_write(fWrite), .init_we(1'b0), .init_addr(32'h0),
        .init_data(32'h0), .data(fData), .hold(fHold), .err(fErr),
        .rd_count(fRdCount), .wr_count(fWrCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic collectResponse(input string tag);
        exp_t e;
        int   holdCycles = 0;
        while (holdOut && holdCycles < 20) begin
            holdCycles++;
            @(negedge clk);
        end
        checkOutput({tag, ".holdCycles"}, holdCycles, 2);
        if (sbQ.size() == 0) begin
            checkOutput({tag, ".sbEmpty"}, 1, 0);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, ".err"}, errOut, e.err);
            if (e.chkData) begin
                checkOutput({tag, ".data"}, dataOut, e.data);
                lastData = e.data;
            end
            if (e.legal) begin
                if (e.isStore) expWr++;
                else expRd++;
            end
        end
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        checkOutput({tag, ".rdCount"}, rdCount, expRd);
        checkOutput({tag, ".wrCount"}, wrCount, expWr);
    endtask

    // Entered and left at posedge+1; expectation is pushed as the request is driven.
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rd, input logic wr);
        exp_t        e;
        logic [7:0]  idx;
        idx       = addr[9:2];
        e.isStore = wr;
        e.legal   = (addr[1:0] == 2'b00) && (addr[31:10] == '0);
        e.err     = !e.legal;
        e.chkData = !wr || !e.legal;
        e.data    = !e.legal ? 32'h0 : modelMem[idx];
        if (wr && e.legal) modelMem[idx] = wdata;
        sbQ.push_back(e);
        dataAddress = addr;
        writeData   = wdata;
        memRead     = rd;
        memWrite    = wr;
        @(negedge clk);
        checkOutput({tag, ".reqErr"}, errOut, 1'b0);
        checkOutput({tag, ".reqData"}, dataOut, lastData);
        collectResponse(tag);
    endtask

    task automatic initWrite(input logic [31:0] addr, input logic [31:0] value);
        initAddr = addr;
        initData = value;
        initWe   = 1'b1;
        if (addr[1:0] == 2'b00 && addr[31:10] == '0) modelMem[addr[9:2]] = value;
        @(negedge clk);
        checkOutput("init.err", errOut, 1'b0);
        @(posedge clk);
        #1;
        initWe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; fReset = 1'b0;
        dataAddress = '0; writeData = '0; memRead = 1'b1; memWrite = 1'b0;
        initWe = 1'b0; initAddr = '0; initData = '0;
        fAddress = '0; fWriteData = '0; fRead = 1'b0; fWrite = 1'b0;

        @(negedge clk);
        checkOutput("reset.holdLow", holdOut, 1'b0);
        @(negedge clk);
        checkOutput("reset.data", dataOut, 32'h0);
        checkOutput("reset.err", errOut, 1'b0);
        checkOutput("reset.rdCount", rdCount, 0);
        checkOutput("reset.wrCount", wrCount, 0);
        @(posedge clk);
        #1;
        reset = 1'b1; fReset = 1'b1; memRead = 1'b0;

        initWrite(32'h44, 32'h12345678);
        initWrite(32'h80, 32'hA5A5A5A5);
        initWrite(32'h1000, 32'hBAD0BAD0);

        applyStimulus("storeDeadbeef", 32'h40, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus("load40", 32'h40, 32'h0, 1'b1, 1'b0);
        applyStimulus("b2bLoad40", 32'h40, 32'h0, 1'b1, 1'b0);
        applyStimulus("b2bLoad44", 32'h44, 32'h0, 1'b1, 1'b0);
        applyStimulus("loadOutOfRange", 32'h400, 32'h0, 1'b1, 1'b0);
        applyStimulus("loadMisaligned", 32'h41, 32'h0, 1'b1, 1'b0);
        applyStimulus("load44Again", 32'h44, 32'h0, 1'b1, 1'b0);

        // Store aborted by reset while in WAIT: RAM and counters must not see it.
        dataAddress = 32'h80; writeData = 32'h55AA55AA; memWrite = 1'b1;
        @(negedge clk);
        checkOutput("abort.reqHold", holdOut, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort.holdDrop", holdOut, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1; memWrite = 1'b0;
        lastData = '0; expRd = 0; expWr = 0;
        checkOutput("abort.rdCount", rdCount, 0);
        checkOutput("abort.wrCount", wrCount, 0);
        checkOutput("abort.data", dataOut, 32'h0);
        @(negedge clk);
        checkOutput("abort.idleHold", holdOut, 1'b0);
        @(posedge clk);
        #1;

        applyStimulus("load80Kept", 32'h80, 32'h0, 1'b1, 1'b0);
        applyStimulus("load40Kept", 32'h40, 32'h0, 1'b1, 1'b0);
        applyStimulus("readWriteIsStore", 32'h84, 32'h0BADF00D, 1'b1, 1'b1);
        applyStimulus("load84", 32'h84, 32'h0, 1'b1, 1'b0);

        // Zero-latency instance: no stall, combinational read, narrow saturating counters.
        fAddress = 32'h08; fWriteData = 32'h0000FFFF; fWrite = 1'b1;
        @(negedge clk);
        checkOutput("fast.storeHold", fHold, 1'b0);
        @(posedge clk);
        #1;
        fastWr = 1;
        checkOutput("fast.wrCount1", fWrCount, fastWr);
        fWrite = 1'b0; fRead = 1'b1;
        @(negedge clk);
        checkOutput("fast.loadData", fData, 32'h0000FFFF);
        checkOutput("fast.loadHold", fHold, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("fast.rdCount", fRdCount, 1);
        fRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fAddress = 32'h0C; fWriteData = i; fWrite = 1'b1;
            @(posedge clk);
            #1;
            fastWr = (fastWr == 3) ? 3 : fastWr + 1;
            checkOutput("fast.wrSat", fWrCount, fastWr);
            fWrite = 1'b0;
        end
        fAddress = 32'h41; fRead = 1'b1;
        @(negedge clk);
        checkOutput("fast.misErr", fErr, 1'b1);
        checkOutput("fast.misData", fData, 32'h0);
        @(posedge clk);
        #1;
        fAddress = 32'h0C;
        @(negedge clk);
        checkOutput("fast.lastStore", fData, 32'h3);
        checkOutput("fast.okErr", fErr, 1'b0);
        @(posedge clk);
        #1;
        fRead = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface.
- Takes the processor's data_address, write_data, mem_read and mem_write, services them from an internal word-addressed RAM, and returns read data on data.
- Emulates a slow memory: drives hold to stall PC update and register write-back for a programmable number of cycles per access.
- Sits beside the processor core in the SoC/testbench top, replacing an ideal zero-latency data memory.

Parameters:
- DEPTH, 256, number of 32-bit words (power of 2, 2..4096)
- LATENCY, 2, stall cycles per access (0..15)
- CNT_W, 16, width of saturating access counters

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- data_address  input  32  byte address from processor
- write_data  input  32  store data from processor
- mem_read  input  1  load request, level
- mem_write  input  1  store request, level
- init_we  input  1  backdoor preload write enable
- init_addr  input  32  backdoor byte address
- init_data  input  32  backdoor data
- data  output  32  load data to processor
- hold  output  1  stall to processor
- err  output  1  one-cycle pulse on out-of-range or misaligned access
- rd_count  output  CNT_W  completed loads, saturating
- wr_count  output  CNT_W  completed stores, saturating

Behaviour:
- Reset (reset==0 at posedge):
  - FSM to IDLE; data, err, rd_count, wr_count = 0.
  - hold = 0 while reset is low.
  - Any pending access is discarded and its write is not performed.
  - RAM contents are retained.
- req = mem_read | mem_write. If both are high, the access is a store.
- Word index = data_address[log2(DEPTH)+1:2].
  - Out of range: any address bit above that field set.
  - Misaligned: data_address[1:0] != 0.
  - Both cases are illegal.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, req=0: hold=0.
  - IDLE, req=1, LATENCY>0: hold=1 combinationally in the same cycle. Latch address, write_data and op. Load the counter. Next state is WAIT, or DONE if LATENCY==1.
  - WAIT: hold=1. Counter decrements. When the counter expires, next state is DONE.
  - Hold is high for exactly LATENCY consecutive cycles, starting with the request cycle.
  - DONE: hold=0; the processor commits on this cycle's posedge.
    - Load: data = RAM[latched index], registered, valid throughout the DONE cycle.
    - Store: RAM[latched index] = latched data at the posedge ending DONE.
    - rd_count or wr_count increments at that posedge; saturates at all-ones.
    - Next state is IDLE. A new request is seen in IDLE the following cycle, so back-to-back accesses each get the full stall.
- Inputs changing during WAIT/DONE are ignored; latched values are used.
- LATENCY==0:
  - FSM stays in IDLE; hold constant 0.
  - data is combinational RAM[index] of the current address.
  - Stores write at the request-cycle posedge; counters update at that same posedge.
- Illegal access:
  - Full stall still applies.
  - In DONE: data=0, no RAM write, err=1 for exactly that cycle.
  - Counters do not increment.
- data holds its last value outside DONE (LATENCY>0).
- Backdoor preload:
  - init_we writes RAM[init index] at posedge only when the FSM is in IDLE and req=0.
  - Otherwise it is ignored.
  - An illegal init address is ignored and does not pulse err.

Test Plan:
- LATENCY=2, DEPTH=256. Store 0xDEADBEEF to 0x40 -> hold=1 for 2 cycles, then DONE with hold=0; RAM[16]=0xDEADBEEF after the DONE edge; wr_count=1.
- Load 0x40 next -> hold=1 for 2 cycles; data=0xDEADBEEF during DONE; rd_count=1.
- Back-to-back loads of 0x40 then 0x44 (preloaded 0x12345678) -> two separate 2-cycle stalls separated by DONE/IDLE; data=0xDEADBEEF then 0x12345678.
- Load 0x400 (out of range) and load 0x41 (misaligned) -> 2-cycle stall each; data=0 and err=1 for one cycle each; counters unchanged.
- Store 0x55AA55AA to 0x80, reset low in the WAIT cycle -> hold=0 immediately; state IDLE; RAM[32] unchanged; counters=0. Previously written RAM[16] is still 0xDEADBEEF.
- LATENCY=0 build: store then load 0x08 with value 0x0000FFFF -> hold never asserted; load returns 0x0000FFFF in the request cycle.
- Counter saturation with CNT_W=2: 5 stores -> wr_count=3.
